// File: rtl/adc_scan_sequencer.sv
// Three-channel ADC scan sequencer: one scan per PWM trigger, coherent snapshot publish,
// stall timeout and overrun detection. Define ADC_OVERSAMPLE_EN to average four conversions per channel.
module adc_scan_sequencer #(
  parameter int          DATA_W      = 16,
  parameter int          TIMEOUT_CYC = 255,
  parameter int unsigned RESET_VAL   = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              trigger,
  output logic              conv_start,
  output logic [1:0]        conv_ch,
  input  logic              conv_done,
  input  logic [DATA_W-1:0] conv_data,
  output logic [DATA_W-1:0] adc0,
  output logic [DATA_W-1:0] adc1,
  output logic [DATA_W-1:0] adc2,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);

  localparam int                TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [DATA_W-1:0] RST_V    = DATA_W'(RESET_VAL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] sh0_q, sh0_d;
  logic [DATA_W-1:0] sh1_q, sh1_d;
  logic [DATA_W-1:0] adc0_q, adc0_d;
  logic [DATA_W-1:0] adc1_q, adc1_d;
  logic [DATA_W-1:0] adc2_q, adc2_d;
  logic              sv_q, sv_d;
  logic              terr_q, terr_d;
  logic              ovr_q, ovr_d;

  // Per-conversion result and whether it finishes the current channel.
  logic [DATA_W-1:0] result;
  logic              ch_complete;

`ifdef ADC_OVERSAMPLE_EN
  logic [1:0]        rep_q, rep_d;
  logic [DATA_W+1:0] acc_q, acc_d;
  logic [DATA_W+1:0] sum;

  always_comb begin
    sum         = acc_q + {2'b00, conv_data};
    result      = DATA_W'(sum >> 2);
    ch_complete = (rep_q == 2'd3);
  end
`else
  always_comb begin
    result      = conv_data;
    ch_complete = 1'b1;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= 2'd0;
      timer_q <= '0;
      sh0_q   <= RST_V;
      sh1_q   <= RST_V;
      adc0_q  <= RST_V;
      adc1_q  <= RST_V;
      adc2_q  <= RST_V;
      sv_q    <= 1'b0;
      terr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      rep_q   <= 2'd0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      timer_q <= timer_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      adc0_q  <= adc0_d;
      adc1_q  <= adc1_d;
      adc2_q  <= adc2_d;
      sv_q    <= sv_d;
      terr_q  <= terr_d;
      ovr_q   <= ovr_d;
`ifdef ADC_OVERSAMPLE_EN
      rep_q   <= rep_d;
      acc_q   <= acc_d;
`endif
    end
  end

  // Next-state logic. Handshake: conv_start is a one-cycle request for channel conv_ch;
  // the ADC answers with a one-cycle conv_done carrying conv_data, only one request outstanding.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    timer_d = timer_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    adc0_d  = adc0_q;
    adc1_d  = adc1_q;
    adc2_d  = adc2_q;
    sv_d    = 1'b0;
    terr_d  = terr_q;
    ovr_d   = ovr_q;
`ifdef ADC_OVERSAMPLE_EN
    rep_d   = rep_q;
    acc_d   = acc_q;
`endif

    if (trigger && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (trigger && enable && !terr_q) begin
          state_d = ST_REQ;
          ch_d    = 2'd0;
`ifdef ADC_OVERSAMPLE_EN
          rep_d   = 2'd0;
          acc_d   = '0;
`endif
        end
      end

      ST_REQ: begin
        if (!enable) begin
          state_d = ST_IDLE;
          ch_d    = 2'd0;
        end else begin
          state_d = ST_WAIT;
          timer_d = '0;
        end
      end

      ST_WAIT: begin
        if (!enable) begin
          // Abort silently: any done arriving now or later is dropped.
          state_d = ST_IDLE;
          ch_d    = 2'd0;
        end else if (conv_done) begin
          timer_d = '0;
`ifdef ADC_OVERSAMPLE_EN
          if (ch_complete) begin
            rep_d = 2'd0;
            acc_d = '0;
          end else begin
            rep_d = rep_q + 2'd1;
            acc_d = sum;
          end
`endif
          if (!ch_complete) begin
            state_d = ST_REQ;
          end else if (ch_q == 2'd2) begin
            adc0_d  = sh0_q;
            adc1_d  = sh1_q;
            adc2_d  = result;
            sv_d    = 1'b1;
            state_d = ST_IDLE;
            ch_d    = 2'd0;
          end else begin
            if (ch_q == 2'd0) begin
              sh0_d = result;
            end else begin
              sh1_d = result;
            end
            ch_d    = ch_q + 2'd1;
            state_d = ST_REQ;
          end
        end else if (timer_q == TMR_LAST) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
          ch_d    = 2'd0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ch_d    = 2'd0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    conv_start   = (state_q == ST_REQ);
    busy         = (state_q != ST_IDLE);
    conv_ch      = ch_q;
    adc0         = adc0_q;
    adc1         = adc1_q;
    adc2         = adc2_q;
    sample_valid = sv_q;
    timeout_err  = terr_q;
    overrun      = ovr_q;
  end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
Schedules conversions on the single shared 3-channel ADC front-end and delivers a coherent snapshot of phase-current/DC-link samples (adc0..adc2) to the protection/control logic once per PWM sample trigger. It issues per-channel conversion requests through a start/done handshake, latches results into shadow registers, and publishes all three channels on the same clock edge. It detects stalled conversions (timeout) and triggers that arrive mid-scan (overrun).

Parameters:
DATA_W, 16, width of conv_data and adc0..adc2
TIMEOUT_CYC, 255, max WAIT cycles per conversion before timeout (>=2)
RESET_VAL, 2048, reset value of adc0..adc2 (mid-scale, inside protection window)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; low aborts scan and blocks triggers
trigger  in  1  single-cycle sample request from PWM sync
conv_start  out  1  single-cycle conversion request to ADC interface
conv_ch  out  2  channel for current request (0,1,2); held stable through WAIT
conv_done  in  1  single-cycle conversion-complete strobe
conv_data  in  DATA_W  conversion result, valid with conv_done
adc0  out  DATA_W  published channel 0 result
adc1  out  DATA_W  published channel 1 result
adc2  out  DATA_W  published channel 2 result
sample_valid  out  1  one-cycle pulse: adc0..adc2 just updated
busy  out  1  high whenever FSM not in IDLE
timeout_err  out  1  sticky: conversion did not complete within TIMEOUT_CYC
overrun  out  1  sticky: trigger received while busy

Behaviour:
- Reset (dominant over all other inputs): FSM=IDLE, ch=0, timer=0, conv_start=0, conv_ch=0, adc0..adc2=RESET_VAL, shadows=RESET_VAL, sample_valid=0, busy=0, timeout_err=0, overrun=0. Reset mid-scan aborts immediately.
- States: IDLE, REQ, WAIT.
- IDLE: trigger && enable && !timeout_err -> REQ, ch=0. Otherwise stay. conv_done in IDLE ignored.
- REQ (1 cycle): conv_start=1, conv_ch=ch; -> WAIT, timer=0.
- WAIT: conv_done=1 -> shadow[ch]<=conv_data; if ch<2: ch++ -> REQ; if ch==2: on same edge adc0..adc2<=shadow0, shadow1, conv_data; sample_valid=1 next cycle; -> IDLE.
- WAIT without done: timer++; when timer==TIMEOUT_CYC-1 at an edge without done: timeout_err<=1, -> IDLE, no sample_valid, adc outputs unchanged. Done on the limit cycle wins over timeout.
- timeout_err set: all further triggers ignored until reset.
- Latency: trigger at cycle T, ADC done D cycles after conv_start (D>=1): conv_start for ch0/1/2 at T+1, T+2+D, T+3+2D; sample_valid high in cycle T+3D+4 with adc0..adc2 valid from that cycle.
- trigger while busy (REQ/WAIT): ignored, overrun<=1 (sticky). Trigger on the cycle sample_valid is high (FSM in IDLE) is accepted normally.
- enable low in REQ/WAIT: -> IDLE on next edge, no sample_valid, adc outputs unchanged, no error flag set; conv_done on that cycle discarded.
- busy = (state != IDLE), registered with state.
- adc outputs never change except on sample_valid edge or reset (no partial snapshots).

Optional Feature:
ADC_OVERSAMPLE_EN: when defined, each channel converted 4 times consecutively (REQ/WAIT repeated, conv_ch unchanged); 4 results summed in a DATA_W+2-bit accumulator, published value = sum>>2 (truncate). Timeout applies per conversion. Latency becomes sample_valid at T+12(D+1)+1. When undefined: single conversion per channel, exactly as above.

Test Plan:
- Basic scan, D=1, conv_data 1000/2000/3000 -> conv_start at T+1,T+3,T+5 with conv_ch 0,1,2; sample_valid at T+7; adc0..2=1000/2000/3000; busy high T+1..T+6.
- Reset check: after reset adc0..2=2048, all flags 0; reset asserted in WAIT of ch1 -> IDLE next cycle, no sample_valid, adc0..2=2048.
- Timeout, TIMEOUT_CYC=8, ch1 never done -> timeout_err=1 after 8 WAIT cycles, no sample_valid, adc unchanged; subsequent trigger produces no conv_start; done on 8th WAIT cycle instead -> no timeout, scan completes.
- Overrun: trigger at T and again at T+3 (D=1) -> overrun=1, single scan, sample_valid only at T+7; trigger at T+7 starts new scan at T+8.
- enable dropped during ch2 WAIT -> IDLE, no sample_valid, adc unchanged, timeout_err/overrun stay 0; enable low at trigger -> no conv_start.
- ADC_OVERSAMPLE_EN, D=1, ch0 data 1000,1001,1002,1003 -> adc0=1001; 12 conv_start pulses; sample_valid at T+25.
